// File: rtl/shift_seq_arbiter.sv
// shift_seq_arbiter
//   Shares one iterative shift datapath between two requesters (A, B) with
//   round-robin arbitration. Each op is a logical left (zero fill) or an
//   arithmetic right (sign fill) shift of a WIDTH-bit operand by a 32-bit
//   unsigned amount. Amounts >= WIDTH saturate rather than truncate. At most
//   STEP bit positions are shifted per SHIFT cycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   a_valid/a_ready/a_data/a_amt/a_op   requester A (op: 0 = <<<, 1 = >>>)
//   b_valid/b_ready/b_data/b_amt/b_op   requester B
//   rsp_valid/rsp_ready            result handshake
//   rsp_data                       shifted result
//   rsp_id                         0 = result for A, 1 = result for B
module shift_seq_arbiter #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [31:0]      a_amt,
  input  logic             a_op,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic [31:0]      b_amt,
  input  logic             b_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  // rem only ever holds 0..WIDTH
  localparam int unsigned RW = $clog2(WIDTH + 1);
  localparam logic [RW-1:0] WIDTH_R = RW'(WIDTH);
  localparam logic [RW-1:0] STEP_R  = RW'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             op_q;
  logic             id_q;
  logic [RW-1:0]    rem_q;
  logic             rr_q;        // 1 = prefer B on contention
  logic             rsp_valid_q;

  logic             grant_a_d, grant_b_d;
  logic [31:0]      amt_d;
  logic [RW-1:0]    rem_init_d;
  logic [RW-1:0]    k_d;
  logic [WIDTH-1:0] shifted_d;

  always_comb begin
    grant_a_d  = 1'b0;
    grant_b_d  = 1'b0;
    amt_d      = a_amt;
    rem_init_d = '0;
    k_d        = '0;
    shifted_d  = data_q;

    if (state_q == IDLE) begin
      grant_b_d = b_valid && (!a_valid || rr_q);
      grant_a_d = a_valid && !grant_b_d;
    end

    amt_d = grant_b_d ? b_amt : a_amt;
    // Full 32-bit compare so large amounts saturate instead of wrapping.
    rem_init_d = (amt_d >= 32'(WIDTH)) ? WIDTH_R : amt_d[RW-1:0];

    k_d = (rem_q < STEP_R) ? rem_q : STEP_R;
    if (op_q) shifted_d = $signed(data_q) >>> k_d;
    else      shifted_d = data_q << k_d;
  end

  assign a_ready   = grant_a_d;
  assign b_ready   = grant_b_d;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      op_q        <= 1'b0;
      id_q        <= 1'b0;
      rem_q       <= '0;
      rr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_a_d || grant_b_d) begin
            data_q <= grant_b_d ? b_data : a_data;
            op_q   <= grant_b_d ? b_op : a_op;
            id_q   <= grant_b_d;
            rem_q  <= rem_init_d;
            rr_q   <= !grant_b_d;
            if (rem_init_d == '0) begin
              state_q     <= DONE;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= shifted_d;
          rem_q  <= rem_q - k_d;
          if (rem_q == k_d) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_arbiter.sv
module tb_shift_seq_arbiter;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, a_ready, a_op;
  logic [W-1:0] a_data;
  logic [31:0]  a_amt;
  logic         b_valid, b_ready, b_op;
  logic [W-1:0] b_data;
  logic [31:0]  b_amt;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_seq_arbiter #(.WIDTH(W), .STEP(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt), .b_op(b_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  typedef struct {
    bit           who;   // 0 = A, 1 = B
    logic [W-1:0] data;
    logic [31:0]  amt;
    logic         op;
    logic [W-1:0] exp;
    int unsigned  nsh;   // expected SHIFT cycles
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int n;
    int cyc;
    @(negedge clk);
    if (!v.who) begin
      a_valid = 1'b1; a_data = v.data; a_amt = v.amt; a_op = v.op;
    end else begin
      b_valid = 1'b1; b_data = v.data; b_amt = v.amt; b_op = v.op;
    end
    #1;
    n = 0;
    while (!(v.who ? b_ready : a_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("v%0d_grant", idx), (n < 20), 1);
    if (n >= 20) begin
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 a_valid = 1'b0; b_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!rsp_valid && cyc < 40);
    chk($sformatf("v%0d_latency", idx), cyc, 1 + v.nsh);
    chk($sformatf("v%0d_data", idx), rsp_data, v.exp);
    chk($sformatf("v%0d_id", idx), rsp_id, v.who);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_drop", idx), rsp_valid, 0);
  endtask

  task automatic wait_rsp(input string name);
    int cyc;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    chk(name, (cyc < 40), 1);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 7'h36, 32'hFFFF_FFFF, 1'b0, 7'h00, 2};
    vecs[1]  = '{1'b0, 7'h40, 32'h8000_0000, 1'b1, 7'h7F, 2};
    vecs[2]  = '{1'b0, 7'h2D, 32'd0,         1'b0, 7'h2D, 0};
    vecs[3]  = '{1'b0, 7'h2D, 32'd5,         1'b0, 7'h20, 2};
    vecs[4]  = '{1'b1, 7'h40, 32'd3,         1'b1, 7'h78, 1};
    vecs[5]  = '{1'b1, 7'h55, 32'd4,         1'b1, 7'h7D, 1};
    vecs[6]  = '{1'b0, 7'h55, 32'd7,         1'b0, 7'h00, 2};
    vecs[7]  = '{1'b1, 7'h3F, 32'd5,         1'b1, 7'h01, 2};
    vecs[8]  = '{1'b0, 7'h01, 32'd6,         1'b0, 7'h40, 2};
    vecs[9]  = '{1'b1, 7'h7F, 32'd7,         1'b1, 7'h7F, 2};
    vecs[10] = '{1'b0, 7'h2A, 32'd256,       1'b0, 7'h00, 2};
    vecs[11] = '{1'b1, 7'h2A, 32'd1,         1'b1, 7'h15, 1};
    vecs[12] = '{1'b0, 7'h13, 32'd4,         1'b0, 7'h30, 1};
    vecs[13] = '{1'b1, 7'h2D, 32'd0,         1'b1, 7'h2D, 0};
    vecs[14] = '{1'b1, 7'h2A, 32'd8,         1'b1, 7'h00, 2};

    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_amt = '0; a_op = 1'b0;
    b_valid = 1'b0; b_data = '0; b_amt = '0; b_op = 1'b0;
    rsp_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_a_ready", a_ready, 0);
    chk("reset_b_ready", b_ready, 0);

    for (int i = 0; i < 15; i++) do_op(vecs[i], i);

    // Round robin under constant contention: A, B, A, B.
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_data = 7'h11; a_amt = 32'd1; a_op = 1'b0;
    b_valid = 1'b1; b_data = 7'h05; b_amt = 32'd2; b_op = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      while (!(a_ready || b_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk($sformatf("rr%0d_a_ready", i), a_ready, (i % 2 == 0));
      chk($sformatf("rr%0d_b_ready", i), b_ready, (i % 2 == 1));
      @(posedge clk);
      #1;
      wait_rsp($sformatf("rr%0d_rsp_seen", i));
      chk($sformatf("rr%0d_id", i), rsp_id, i % 2);
      chk($sformatf("rr%0d_data", i), rsp_data, (i % 2 == 0) ? 7'h22 : 7'h14);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Back-pressure in DONE with both requesters pending.
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_data = 7'h55; a_amt = 32'd4; a_op = 1'b1;
    #1 chk("hold_accept", a_ready, 1);
    @(posedge clk);
    #1;
    a_data = 7'h0F; a_amt = 32'd0; b_valid = 1'b1; b_data = 7'h33; b_amt = 32'd0;
    @(negedge clk);
    wait_rsp("hold_rsp_seen");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_valid", i), rsp_valid, 1);
      chk($sformatf("hold%0d_data", i), rsp_data, 7'h7D);
      chk($sformatf("hold%0d_id", i), rsp_id, 0);
      chk($sformatf("hold%0d_ab_ready", i), {a_ready, b_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("hs_cycle_ab_ready", {a_ready, b_ready}, 0);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("after_hs_b_granted", {a_ready, b_ready}, 2'b01);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("after_hs_idle", rsp_valid, 0);

    // Reset during SHIFT abandons the op and restores A preference.
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_data = 7'h36; a_amt = 32'hFFFF_FFFF; a_op = 1'b0;
    #1 chk("rst_accept", a_ready, 1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1 chk("rst_rr_prefers_a", {a_ready, b_ready}, 2'b10);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rsp%0d", i), rsp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
